// File: rtl/seq_detector_param.sv
// Serial bit-sequence detector with a run-time loadable pattern, selectable
// overlap, valid-qualified input and a saturating match counter.
module seq_detector_param #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
  input  logic             x_valid,
  input  logic [PAT_W-1:0] pattern,
  input  logic             load,
  input  logic             overlap,
  input  logic             count_clr,
  output logic             z,
  output logic [CNT_W-1:0] match_count,
  output logic [1:0]       state
);

  // state   | meaning
  // UNARMED | no pattern loaded since reset, input ignored
  // FILL    | collecting the first PAT_W bits after load or non-overlap match
  // HUNT    | history full, every accepted bit is compared
  typedef enum logic [1:0] {
    UNARMED = 2'd0,
    FILL    = 2'd1,
    HUNT    = 2'd2,
    BAD     = 2'd3
  } state_t;

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

  state_t             state_q;
  logic [PAT_W-1:0]   pat_reg;
  logic [PAT_W-1:0]   hist;
  logic [FILL_W-1:0]  fill;

  logic [PAT_W-1:0]   hist_n;
  logic [FILL_W-1:0]  fill_n;
  logic               match_n;

  // Next-bit view: the compare is done on the already-shifted history.
  always_comb begin
    hist_n  = {hist[PAT_W-2:0], x};
    fill_n  = (fill == FILL_MAX) ? fill : fill + FILL_W'(1);
    match_n = (fill_n == FILL_MAX) && (hist_n == pat_reg);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= UNARMED;
      pat_reg     <= '0;
      hist        <= '0;
      fill        <= '0;
      z           <= 1'b0;
      match_count <= '0;
    end else begin
      z <= 1'b0;
      if (load) begin
        pat_reg <= pattern;
        hist    <= '0;
        fill    <= '0;
        state_q <= FILL;
      end else begin
        case (state_q)
          UNARMED: ;
          FILL, HUNT: begin
            if (x_valid) begin
              hist <= hist_n;
              if (match_n) begin
                z <= 1'b1;
                if (match_count != {CNT_W{1'b1}})
                  match_count <= match_count + CNT_W'(1);
                if (overlap) begin
                  fill    <= fill_n;
                  state_q <= HUNT;
                end else begin
                  fill    <= '0;
                  state_q <= FILL;
                end
              end else begin
                fill    <= fill_n;
                state_q <= (fill_n == FILL_MAX) ? HUNT : FILL;
              end
            end
          end
          default: state_q <= UNARMED;
        endcase
      end
      // Clear overrides a same-cycle increment; z is unaffected.
      if (count_clr)
        match_count <= '0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: a 4-bit/8-bit instance for the main
// scenarios and a 2-bit/2-bit instance for counter saturation.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       x = 1'b0;
  logic       x_valid = 1'b0;
  logic [3:0] pattern = 4'b0000;
  logic [1:0] pattern2 = 2'b11;
  logic       load = 1'b0;
  logic       overlap = 1'b1;
  logic       count_clr = 1'b0;

  logic       z, z2;
  logic [7:0] match_count;
  logic [1:0] match_count2;
  logic [1:0] state, state2;

  int total = 0;
  int bad = 0;

  seq_detector_param #(.PAT_W(4), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .pattern(pattern),
    .load(load), .overlap(overlap), .count_clr(count_clr),
    .z(z), .match_count(match_count), .state(state)
  );

  seq_detector_param #(.PAT_W(2), .CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .pattern(pattern2),
    .load(load), .overlap(overlap), .count_clr(count_clr),
    .z(z2), .match_count(match_count2), .state(state2)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are checked there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    x = b;
    x_valid = 1'b1;
    step();
    x_valid = 1'b0;
  endtask

  task automatic do_load(input logic [3:0] p, input logic ov);
    pattern = p;
    overlap = ov;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic clear_count();
    count_clr = 1'b1;
    step();
    count_clr = 1'b0;
  endtask

  logic [6:0] s7;
  logic [6:0] z7;
  logic [7:0] s8;
  logic [7:0] z8;
  logic [7:0] st8;

  initial begin
    // 1: reset, then valid ones with no load
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_z", 32'(z), 32'd0);
    chk("rst_count", 32'(match_count), 32'd0);
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b1);
      chk("unarmed_z", 32'(z), 32'd0);
    end
    chk("unarmed_state", 32'(state), 32'd0);
    chk("unarmed_count", 32'(match_count), 32'd0);

    // 2: overlap, 1001001 -> matches after bits 4 and 7
    do_load(4'b1001, 1'b1);
    chk("load_state", 32'(state), 32'd1);
    s7 = 7'b1001001;
    z7 = 7'b0001001;
    for (int i = 0; i < 7; i++) begin
      send_bit(s7[6-i]);
      chk("ovl_z", 32'(z), 32'(z7[6-i]));
    end
    chk("ovl_count", 32'(match_count), 32'd2);
    chk("ovl_state", 32'(state), 32'd2);

    // 3: non-overlap, 10010010 -> one match, back to FILL, HUNT after bit 8
    clear_count();
    chk("clr_count", 32'(match_count), 32'd0);
    do_load(4'b1001, 1'b0);
    s8  = 8'b10010010;
    z8  = 8'b00010000;
    st8 = 8'b00000001;
    for (int i = 0; i < 8; i++) begin
      send_bit(s8[7-i]);
      chk("novl_z", 32'(z), 32'(z8[7-i]));
      chk("novl_state", 32'(state), st8[7-i] ? 32'd2 : 32'd1);
    end
    chk("novl_count", 32'(match_count), 32'd1);

    // 4: x_valid gaps between bits
    clear_count();
    do_load(4'b1001, 1'b1);
    for (int i = 0; i < 4; i++) begin
      send_bit((i == 0 || i == 3) ? 1'b1 : 1'b0);
      chk("gap_bit_z", 32'(z), (i == 3) ? 32'd1 : 32'd0);
      x = ~x;
      step();
      chk("gap_z", 32'(z), 32'd0);
      step();
      chk("gap_z", 32'(z), 32'd0);
    end
    chk("gap_count", 32'(match_count), 32'd1);
    chk("gap_state", 32'(state), 32'd2);

    // 5: saturation on the 2-bit instance, pattern 11
    clear_count();
    chk("sat_clr", 32'(match_count2), 32'd0);
    do_load(4'b1001, 1'b1);
    for (int i = 0; i < 6; i++) begin
      send_bit(1'b1);
      chk("sat_z", 32'(z2), (i == 0) ? 32'd0 : 32'd1);
    end
    chk("sat_count", 32'(match_count2), 32'd3);
    count_clr = 1'b1;
    send_bit(1'b1);
    count_clr = 1'b0;
    chk("clr_match_z", 32'(z2), 32'd1);
    chk("clr_match_count", 32'(match_count2), 32'd0);

    // 6a: reset mid-stream disarms
    do_load(4'b1001, 1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_z", 32'(z), 32'd0);
    chk("mid_rst_state", 32'(state), 32'd0);
    chk("mid_rst_count", 32'(match_count), 32'd0);
    send_bit(1'b1);
    chk("mid_rst_bit_z", 32'(z), 32'd0);
    chk("mid_rst_bit_state", 32'(state), 32'd0);

    // 6b: reload mid-stream discards stale history
    do_load(4'b1001, 1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    do_load(4'b0110, 1'b1);
    chk("reload_state", 32'(state), 32'd1);
    send_bit(1'b0);
    chk("reload_z1", 32'(z), 32'd0);
    send_bit(1'b1);
    chk("reload_z2", 32'(z), 32'd0);
    send_bit(1'b1);
    chk("reload_z3", 32'(z), 32'd0);
    send_bit(1'b0);
    chk("reload_z4", 32'(z), 32'd1);
    step();
    chk("reload_z_drop", 32'(z), 32'd0);
    chk("reload_count", 32'(match_count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
